// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: serial line, control and sample outputs shared by the RX FSM, sampler and deserializer.
interface uart_rx_sampler_if #(parameter int PRESCALE_W = 6);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  enable;
    logic                  rx_sync;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_count;
    logic                  Sampled_Bit;
    logic                  sample_valid;
    logic                  start_glitch;
    modport master (
        output RX_IN, Prescale, enable,
        input  rx_sync, edge_cnt, bit_count, Sampled_Bit, sample_valid, start_glitch
    );
    modport slave (
        input  RX_IN, Prescale, enable,
        output rx_sync, edge_cnt, bit_count, Sampled_Bit, sample_valid, start_glitch
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises RX_IN, times bits at Prescale clocks per bit and emits one sample per bit.
// Define SAMPLER_MAJORITY_EN for a three-sample majority vote; otherwise a single mid-bit sample is used.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int FRAME_BITS = 11
) (
    input logic              CLK,
    input logic              RST,
    uart_rx_sampler_if.slave bus
);
    localparam logic [PRESCALE_W-1:0] min_ps   = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] one      = PRESCALE_W'(1);
    localparam logic [3:0]            last_bit = 4'(FRAME_BITS - 1);
    logic                  rx_meta, bit_end, fire, upd, vote, glitch_bit;
    logic [PRESCALE_W-1:0] eff_ps, half;
    // The all-ones wrap keeps the counter alive if Prescale shrinks mid-frame.
    always_comb begin
        eff_ps  = (bus.Prescale < min_ps || bus.Prescale[0]) ? min_ps : bus.Prescale;
        half    = eff_ps >> 1;
        bit_end = bus.edge_cnt == eff_ps - one || &bus.edge_cnt;
        fire    = bus.enable && bus.edge_cnt == half + one;
    end
    always_ff @(posedge CLK or negedge RST)
        if (!RST) {bus.rx_sync, rx_meta} <= 2'b11;
        else {bus.rx_sync, rx_meta} <= {rx_meta, bus.RX_IN};
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            bus.edge_cnt  <= '0;
            bus.bit_count <= '0;
        end else if (!bus.enable) begin
            bus.edge_cnt  <= '0;
            bus.bit_count <= '0;
        end else if (bit_end) begin
            bus.edge_cnt  <= '0;
            bus.bit_count <= bus.bit_count >= last_bit ? 4'd0 : bus.bit_count + 4'd1;
        end else begin
            bus.edge_cnt <= bus.edge_cnt + one;
        end
`ifdef SAMPLER_MAJORITY_EN
    logic s0, s1;
    // The third sample feeds the vote directly so the pulse lands at half+2.
    always_comb begin
        vote       = (s0 & s1) | (s0 & bus.rx_sync) | (s1 & bus.rx_sync);
        upd        = fire;
        glitch_bit = vote;
    end
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (bus.edge_cnt == half - one) s0 <= bus.rx_sync;
            if (bus.edge_cnt == half) s1 <= bus.rx_sync;
        end
`else
    always_comb begin
        vote       = bus.rx_sync;
        upd        = bus.enable && bus.edge_cnt == half;
        glitch_bit = bus.Sampled_Bit;
    end
`endif
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            bus.Sampled_Bit  <= 1'b1;
            bus.sample_valid <= 1'b0;
            bus.start_glitch <= 1'b0;
        end else begin
            bus.sample_valid <= fire;
            bus.start_glitch <= fire && bus.bit_count == 4'd0 && glitch_bit;
            if (upd) bus.Sampled_Bit <= vote;
        end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames with a queued scoreboard checked by an independent pulse monitor.
module tb_uart_rx_sampler;
    typedef struct {
        int   bit_idx;
        logic val;
        logic glitch;
        int   edge_pos;
        int   gap;
    } exp_t;
`ifdef SAMPLER_MAJORITY_EN
    localparam logic glitch_vote = 1'b1;
`else
    localparam logic glitch_vote = 1'b0;
`endif
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    exp_t sb[$];
    uart_rx_sampler_if #(.PRESCALE_W(6)) ifc ();
    uart_rx_sampler #(.PRESCALE_W(6), .FRAME_BITS(11)) dut (.CLK(CLK), .RST(RST), .bus(ifc.slave));
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    // Monitor: every sample_valid pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (ifc.sample_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(ifc.bit_count), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bit_count", 32'(ifc.bit_count), 32'(e.bit_idx));
                check("sampled_bit", 32'(ifc.Sampled_Bit), 32'(e.val));
                check("edge_cnt", 32'(ifc.edge_cnt), 32'(e.edge_pos));
                check("start_glitch", 32'(ifc.start_glitch), 32'(e.glitch));
                if (e.gap != 0) check("pulse_gap", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
        end else if (ifc.start_glitch) begin
            check("stray_glitch", 32'(ifc.start_glitch), 32'd0);
        end
    end
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic idle(input int n);
        ifc.enable = 1'b0;
        ifc.RX_IN  = 1'b1;
        repeat (n) tick();
    endtask
    // Drives nbits of a frame; bit g gets a one-cycle inverted pulse that reaches rx_sync at edge_cnt 8.
    task automatic run_frame(input logic [10:0] bits, input int ps, input int eff, input int nbits,
                             input int g, input logic gexp);
        for (int i = 0; i < nbits; i++) begin
            exp_t e;
            e.bit_idx  = i;
            e.val      = (i == g) ? gexp : bits[i];
            e.glitch   = (i == 0) && e.val;
            e.edge_pos = eff / 2 + 2;
            e.gap      = (i == 0) ? 0 : eff;
            sb.push_back(e);
        end
        ifc.Prescale = 6'(ps);
        ifc.enable   = 1'b1;
        for (int c = 0; c < nbits * eff; c++) begin
            ifc.RX_IN = (c / eff == g && c % eff == 6) ? ~bits[c / eff] : bits[c / eff];
            tick();
        end
    endtask
    initial begin
        ifc.RX_IN    = 1'b1;
        ifc.enable   = 1'b0;
        ifc.Prescale = 6'd8;
        repeat (3) tick();
        check("rst_rx_sync", 32'(ifc.rx_sync), 32'd1);
        check("rst_edge_cnt", 32'(ifc.edge_cnt), 32'd0);
        check("rst_bit_count", 32'(ifc.bit_count), 32'd0);
        check("rst_sampled", 32'(ifc.Sampled_Bit), 32'd1);
        check("rst_valid", 32'(ifc.sample_valid), 32'd0);
        check("rst_glitch", 32'(ifc.start_glitch), 32'd0);
        RST = 1'b1;
        idle(100);
        check("idle_rx_sync", 32'(ifc.rx_sync), 32'd1);
        check("idle_sampled", 32'(ifc.Sampled_Bit), 32'd1);
        check("idle_bit_count", 32'(ifc.bit_count), 32'd0);
        // 0xA5, even parity 0, stop 1: 0,1,0,1,0,0,1,0,1,0,1
        run_frame({1'b1, 1'b0, 8'hA5, 1'b0}, 8, 8, 11, -1, 1'b0);
        check("wrap_bit_count", 32'(ifc.bit_count), 32'd0);
        check("wrap_edge_cnt", 32'(ifc.edge_cnt), 32'd0);
        run_frame({1'b1, 1'b0, 8'h3C, 1'b0}, 8, 8, 11, -1, 1'b0);
        idle(5);
        check("clear_edge_cnt", 32'(ifc.edge_cnt), 32'd0);
        ifc.enable = 1'b1;
        ifc.RX_IN  = 1'b0;
        repeat (4) tick();
        check("short_en_edge", 32'(ifc.edge_cnt), 32'd4);
        idle(10);
        run_frame({1'b1, 1'b0, 8'hFF, 1'b0}, 16, 16, 11, 1, glitch_vote);
        idle(5);
        run_frame(11'h7FF, 8, 8, 1, -1, 1'b0);
        idle(5);
        run_frame({1'b1, 1'b0, 8'hA5, 1'b0}, 8, 8, 5, -1, 1'b0);
        tick();
        tick();
        check("pre_rst_bit_count", 32'(ifc.bit_count), 32'd5);
        check("pre_rst_sampled", 32'(ifc.Sampled_Bit), 32'd0);
        ifc.RX_IN = 1'b1;
        RST = 1'b0;
        #1;
        check("mid_rst_edge_cnt", 32'(ifc.edge_cnt), 32'd0);
        check("mid_rst_bit_count", 32'(ifc.bit_count), 32'd0);
        check("mid_rst_sampled", 32'(ifc.Sampled_Bit), 32'd1);
        check("mid_rst_rx_sync", 32'(ifc.rx_sync), 32'd1);
        check("mid_rst_valid", 32'(ifc.sample_valid), 32'd0);
        idle(2);
        RST = 1'b1;
        idle(3);
        run_frame({1'b1, 1'b0, 8'hA5, 1'b0}, 8, 8, 11, -1, 1'b0);
        idle(5);
        run_frame({1'b1, 1'b1, 8'h5A, 1'b0}, 4, 8, 11, -1, 1'b0);
        idle(20);
        check("pending_pulses", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling front end of the UART receive path, directly upstream of the RX deserializer. Synchronises the raw `RX_IN` line and times each bit with an edge counter running at `Prescale` clocks per bit. Each bit gets a majority-voted `Sampled_Bit` value, and the block drives the `bit_count` index the deserializer uses to place data bits. The RX FSM gates it through `enable` and uses `start_glitch` to abort false starts.

## Interface
- `PRESCALE_W`, default 6: width of the `Prescale` input and of `edge_cnt`.
- `FRAME_BITS`, default 11: bits per frame (start + 8 data + parity + stop); last `bit_count` value is `FRAME_BITS-1`.
- `CLK` in 1: receiver oversampling clock.
- `RST` in 1: reset, asynchronous, active-low.
- `RX_IN` in 1: raw serial line, idle high, asynchronous to `CLK`.
- `Prescale` in `PRESCALE_W`: clocks per bit; legal even values 8..32, quasi-static.
- `enable` in 1: from RX FSM; high while a frame is being received.
- `rx_sync` out 1: synchronised `RX_IN`, for FSM start detection.
- `edge_cnt` out `PRESCALE_W`: position inside the current bit, 0..`Prescale`-1.
- `bit_count` out 4: bit index in frame, 0 = start, 1..8 = data, 9 = parity, 10 = stop.
- `Sampled_Bit` out 1: voted value of the current bit.
- `sample_valid` out 1: one-cycle pulse when `Sampled_Bit` is updated.
- `start_glitch` out 1: one-cycle pulse when the start bit samples high.

## Operation
- Synchroniser: two flops on `RX_IN`, both reset to 1. The second flop is `rx_sync`, and all sampling uses `rx_sync`.
- Let `half = Prescale >> 1`. A `Prescale` below 8 or odd is treated as 8 (`eff_ps`), and `half` is derived from `eff_ps`.
- Edge counter with `enable` high:
  - `edge_cnt` increments each cycle.
  - At `eff_ps-1` it wraps to 0 and `bit_count` increments.
- Frame wrap: at `bit_count == FRAME_BITS-1` with `edge_cnt == eff_ps-1`, `bit_count` returns to 0. This supports back-to-back frames.
- Clearing: with `enable` low, `edge_cnt` and `bit_count` are held at 0 on the next edge. Vote registers and `Sampled_Bit` keep their value.
- Vote captures: `rx_sync` is captured into s0, s1, s2 at `edge_cnt` = `half-1`, `half`, `half+1`.
- Vote output: at `edge_cnt == half+2`, `Sampled_Bit` ← majority(s0,s1,s2) and `sample_valid` pulses for exactly one cycle.
- Start glitch: `start_glitch` pulses in the same cycle as `sample_valid` when `bit_count == 0` and the voted bit is 1.
  - The sampler keeps counting after a glitch.
  - The FSM is responsible for dropping `enable`.
- Reset mid-frame: all counters, vote registers and outputs return to their reset values immediately, asynchronously.

## Timing
- Reset values:
  - `rx_sync` = 1, synchroniser flops = 1.
  - `edge_cnt` = 0, `bit_count` = 0.
  - `Sampled_Bit` = 1, s0/s1/s2 = 1.
  - `sample_valid` = 0, `start_glitch` = 0.
- `RX_IN` to `rx_sync` latency: 2 `CLK` edges.
- Vote latency: `sample_valid` rises 1 cycle after the s2 capture.
- `bit_count` is stable for the whole pulse, so the deserializer writes `DATA[bit_count-1]` with no skew.
- `enable` rising: first counted cycle has `edge_cnt` = 0. A rise and fall in the same bit produces no `sample_valid`.
- `Prescale` changes are only legal while `enable` is low. Behaviour mid-frame is undefined but must not lock up: `edge_cnt` wraps at the latest at `2^PRESCALE_W-1`.
- All outputs are registered. There is no combinational path from `RX_IN` to any output.

## Configuration
- Macro: `SAMPLER_MAJORITY_EN`.
- Defined: three-sample majority vote as described above.
- Undefined:
  - Single sample only: `Sampled_Bit` ← `rx_sync` at `edge_cnt == half`.
  - s0/s1/s2 are not implemented.
  - `sample_valid` still pulses at `edge_cnt == half+2`, so latency to the deserializer is unchanged.

## Test plan
- Reset, then `RX_IN` = 1 idle → `rx_sync` = 1, `Sampled_Bit` = 1, `bit_count` = 0, no pulses for 100 cycles.
- `Prescale` = 8, `enable` high, frame 0x A5 LSB-first, even parity, stop 1 → 11 `sample_valid` pulses, 8 cycles apart.
  - Each pulse occurs at `edge_cnt` = 6.
  - `Sampled_Bit` sequence 0,1,0,1,0,0,1,0,1,0,1.
  - `bit_count` 0..10, then back to 0.
- `Prescale` = 16, single-cycle low glitch at `edge_cnt` = 8 inside a 1 bit → `Sampled_Bit` = 1 with the macro defined; 0 with the macro undefined.
- Start bit high (`RX_IN` held 1, `enable` raised) → `start_glitch` pulse at `bit_count` 0, `edge_cnt` = `half+2`.
- `RST` asserted at `bit_count` = 5 → all outputs at reset values on the same cycle; after release, the next frame decodes correctly.
- `Prescale` = 4 (illegal) → behaviour identical to `Prescale` = 8 (pulse spacing 8, vote at `edge_cnt` = 6).
